// File: rtl/ss_edge_event_arbiter.sv
// ss_edge_event_arbiter: per-channel edge detectors whose pending events are granted round-robin onto one valid/ready port.
// Define EDGE_ARB_SYNC_EN to add a 2-flop synchronizer ahead of edge detection (3-cycle priming).
module ss_edge_event_arbiter #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [N_CH-1:0] i_pos_edge,
  input  logic [N_CH-1:0] i_signal,
  output logic            o_valid,
  output logic [CH_W-1:0] o_ch,
  input  logic            i_ready,
  output logic [N_CH-1:0] o_pending,
  output logic [N_CH-1:0] o_overflow,
  input  logic            i_clr_ovf
);

  localparam int unsigned PRIME_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            valid_d;
  logic [CH_W-1:0] ch_d;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] rr_d;
  logic [N_CH-1:0] pending_d;
  logic [N_CH-1:0] ovf_d;
  logic [N_CH-1:0] grant;
  logic [CH_W-1:0] sel;
  logic [CH_W-1:0] idx;
  logic            found;

  logic [N_CH-1:0]    sig_s;
  logic [N_CH-1:0]    prev_q;
  logic [PRIME_W-1:0] prime_cnt;
  logic               prime_c;
  logic [N_CH-1:0]    det_c;
  logic [N_CH-1:0]    det_en;

`ifdef EDGE_ARB_SYNC_EN
  localparam int unsigned PRIME_CYC = 3;

  logic [N_CH-1:0] sync_q1;
  logic [N_CH-1:0] sync_q2;

  // Two-flop synchronizer; priming covers its fill time after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= i_signal;
      sync_q2 <= sync_q1;
    end
  end

  assign sig_s = sync_q2;
`else
  localparam int unsigned PRIME_CYC = 1;

  assign sig_s = i_signal;
`endif

  // Edge detect; nothing is reported while priming so reset-time levels are not edges.
  assign prime_c = (prime_cnt != '0);
  assign det_c   = prime_c ? '0 :
                   (((~prev_q & sig_s) & i_pos_edge) | ((prev_q & ~sig_s) & ~i_pos_edge));
  assign det_en  = det_c & {N_CH{i_en}};

  // Next-state: round-robin pick, handshake, pending and overflow updates.
  always_comb begin
    state_d = state_q;
    valid_d = o_valid;
    ch_d    = o_ch;
    rr_d    = rr_ptr;
    grant   = '0;
    found   = 1'b0;
    sel     = rr_ptr;
    idx     = rr_ptr;

    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found && o_pending[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
      idx = (idx == CH_W'(N_CH - 1)) ? '0 : idx + CH_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          ch_d    = sel;
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (i_ready) begin
          grant   = N_CH'(1) << o_ch;
          valid_d = 1'b0;
          rr_d    = (o_ch == CH_W'(N_CH - 1)) ? '0 : o_ch + CH_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge on the channel being granted re-arms it instead of overflowing.
    pending_d = (o_pending & ~grant) | det_en;
    ovf_d     = (o_overflow & ~{N_CH{i_clr_ovf}}) | (det_en & o_pending & ~grant);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      o_valid    <= 1'b0;
      o_ch       <= '0;
      rr_ptr     <= '0;
      o_pending  <= '0;
      o_overflow <= '0;
      prev_q     <= '0;
      prime_cnt  <= PRIME_W'(PRIME_CYC);
    end else begin
      state_q    <= state_d;
      o_valid    <= valid_d;
      o_ch       <= ch_d;
      rr_ptr     <= rr_d;
      o_pending  <= pending_d;
      o_overflow <= ovf_d;
      prev_q     <= sig_s;
      if (prime_c) begin
        prime_cnt <= prime_cnt - PRIME_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ss_edge_event_arbiter.sv
// Randomized and directed bench for ss_edge_event_arbiter against a behavioural event-scheduler model.
module tb_ss_edge_event_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 2;
`ifdef EDGE_ARB_SYNC_EN
  localparam int PRIME = 3;
`else
  localparam int PRIME = 1;
`endif

  typedef struct {
    logic         rst;
    logic         en;
    logic         ready;
    logic         clr;
    logic [N-1:0] pos;
    logic [N-1:0] sig;
  } stim_t;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_en;
  logic [N-1:0]  i_pos_edge;
  logic [N-1:0]  i_signal;
  logic          o_valid;
  logic [CW-1:0] o_ch;
  logic          i_ready;
  logic [N-1:0]  o_pending;
  logic [N-1:0]  o_overflow;
  logic          i_clr_ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int grants[$];
  int gcyc[$];
  stim_t sq[$];

  logic [N-1:0]  m_prev;
  logic [N-1:0]  m_pend;
  logic [N-1:0]  m_ovf;
  logic          m_valid;
  logic [CW-1:0] m_ch;
  int            m_rr;
  int            m_prime;
`ifdef EDGE_ARB_SYNC_EN
  logic [N-1:0]  m_s1;
  logic [N-1:0]  m_s2;
`endif

  always #5 i_clk = ~i_clk;

  ss_edge_event_arbiter #(.N_CH(N), .CH_W(CW)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_pos_edge (i_pos_edge),
    .i_signal   (i_signal),
    .o_valid    (o_valid),
    .o_ch       (o_ch),
    .i_ready    (i_ready),
    .o_pending  (o_pending),
    .o_overflow (o_overflow),
    .i_clr_ovf  (i_clr_ovf)
  );

  // Behavioural scheduler: events are latched per channel and handed out one at a time in rotating order.
  task automatic model_step();
    logic [N-1:0] s;
    logic [N-1:0] det;
    logic [N-1:0] grant;
    logic [N-1:0] old_pend;
    int first;
`ifdef EDGE_ARB_SYNC_EN
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = i_signal;
`else
    s = i_signal;
`endif
    det = '0;
    if (m_prime > 0) m_prime--;
    else
      for (int c = 0; c < N; c++)
        if (i_pos_edge[c] ? (!m_prev[c] && s[c]) : (m_prev[c] && !s[c])) det[c] = 1'b1;
    m_prev = s;
    if (!i_en) det = '0;
    old_pend = m_pend;
    grant = '0;
    if (m_valid && i_ready) grant[m_ch] = 1'b1;
    if (i_clr_ovf) m_ovf = '0;
    for (int c = 0; c < N; c++) begin
      if (det[c] && old_pend[c] && !grant[c]) m_ovf[c] = 1'b1;
      if (grant[c]) m_pend[c] = det[c];
      else if (det[c]) m_pend[c] = 1'b1;
    end
    if (m_valid) begin
      if (i_ready) begin
        m_valid = 1'b0;
        m_rr    = (int'(m_ch) + 1) % N;
      end
    end else begin
      first = -1;
      for (int d = 0; d < N; d++)
        if (first < 0 && old_pend[(m_rr + d) % N]) first = (m_rr + d) % N;
      if (first >= 0) begin
        m_valid = 1'b1;
        m_ch    = CW'(first);
      end
    end
    if (i_rst) begin
      m_prev = '0; m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_ch = '0; m_rr = 0; m_prime = PRIME;
`ifdef EDGE_ARB_SYNC_EN
      m_s1 = '0; m_s2 = '0;
`endif
    end
  endtask

  task automatic add(input int n, input logic rst, input logic en, input logic [N-1:0] pos,
                     input logic [N-1:0] sig, input logic ready, input logic clr);
    stim_t e;
    e.rst = rst; e.en = en; e.pos = pos; e.sig = sig; e.ready = ready; e.clr = clr;
    repeat (n) sq.push_back(e);
  endtask

  task automatic apply(input stim_t e);
    i_rst = e.rst; i_en = e.en; i_pos_edge = e.pos; i_signal = e.sig; i_ready = e.ready; i_clr_ovf = e.clr;
  endtask

  // Called at a negedge with inputs already driven; logs handshakes that the coming edge will complete.
  task automatic tick();
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      grants.push_back(int'(o_ch));
      gcyc.push_back(cyc);
    end
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic test_reset();
    grants.delete();
    add(2, 1, 1, 4'b1111, 4'b1111, 1, 0);
    add(10, 0, 1, 4'b1111, 4'b1111, 1, 0);
    foreach (sq[k]) begin
      apply(sq[k]); tick(); total++;
      if (o_valid !== m_valid || o_ch !== m_ch || o_pending !== m_pend || o_overflow !== m_ovf) begin
        bad++;
        $display("FAIL reset cyc=%0d got v=%b ch=%0d p=%b o=%b want v=%b ch=%0d p=%b o=%b",
                 cyc, o_valid, o_ch, o_pending, o_overflow, m_valid, m_ch, m_pend, m_ovf);
      end
    end
    sq.delete();
    total++;
    if (grants.size() != 0 || o_pending !== 4'b0000 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_event got grants=%0d pend=%b valid=%b want 0/0000/0", grants.size(), o_pending, o_valid);
    end
  endtask

  task automatic test_single_rise();
    int c0;
    grants.delete(); gcyc.delete();
    c0 = cyc;
    add(1, 1, 1, 4'b0001, 4'b0000, 1, 0);
    add(4, 0, 1, 4'b0001, 4'b0000, 1, 0);
    add(8, 0, 1, 4'b0001, 4'b0001, 1, 0);
    foreach (sq[k]) begin
      apply(sq[k]); tick(); total++;
      if (o_valid !== m_valid || o_ch !== m_ch || o_pending !== m_pend || o_overflow !== m_ovf) begin
        bad++;
        $display("FAIL single_rise cyc=%0d got v=%b ch=%0d p=%b o=%b want v=%b ch=%0d p=%b o=%b",
                 cyc, o_valid, o_ch, o_pending, o_overflow, m_valid, m_ch, m_pend, m_ovf);
      end
    end
    sq.delete();
    total++;
    if (grants.size() != 1 || grants[0] != 0 || gcyc[0] != c0 + 7 + (PRIME - 1) || o_pending !== 4'b0000) begin
      bad++;
      $display("FAIL single_rise_grant got n=%0d ch=%0d at=%0d pend=%b want 1/0/%0d/0000",
               grants.size(), (grants.size() > 0) ? grants[0] : -1, (gcyc.size() > 0) ? gcyc[0] - c0 : -1,
               o_pending, 7 + PRIME - 1);
    end
  endtask

  task automatic test_multi_fall();
    grants.delete(); gcyc.delete();
    add(1, 1, 1, 4'b0000, 4'b1111, 1, 0);
    add(4, 0, 1, 4'b0000, 4'b1111, 1, 0);
    add(12, 0, 1, 4'b0000, 4'b0001, 1, 0);
    foreach (sq[k]) begin
      apply(sq[k]); tick(); total++;
      if (o_valid !== m_valid || o_ch !== m_ch || o_pending !== m_pend || o_overflow !== m_ovf) begin
        bad++;
        $display("FAIL multi_fall cyc=%0d got v=%b ch=%0d p=%b o=%b want v=%b ch=%0d p=%b o=%b",
                 cyc, o_valid, o_ch, o_pending, o_overflow, m_valid, m_ch, m_pend, m_ovf);
      end
    end
    sq.delete();
    total++;
    if (grants.size() != 3 || grants[0] != 1 || grants[1] != 2 || grants[2] != 3 ||
        gcyc[1] - gcyc[0] != 2 || gcyc[2] - gcyc[1] != 2) begin
      bad++;
      $display("FAIL multi_fall_order got n=%0d first=%0d want 3 grants 1,2,3 spaced 2",
               grants.size(), (grants.size() > 0) ? grants[0] : -1);
    end
  endtask

  task automatic test_overflow();
    int mark;
    logic [N-1:0] snap;
    grants.delete();
    snap = '0;
    add(1, 1, 1, 4'b0100, 4'b0000, 0, 0);
    add(4, 0, 1, 4'b0100, 4'b0000, 0, 0);
    add(2, 0, 1, 4'b0100, 4'b0100, 0, 0);
    add(2, 0, 1, 4'b0100, 4'b0000, 0, 0);
    add(4, 0, 1, 4'b0100, 4'b0100, 0, 0);
    mark = sq.size() - 1;
    add(6, 0, 1, 4'b0100, 4'b0100, 1, 0);
    add(1, 0, 1, 4'b0100, 4'b0100, 0, 1);
    add(2, 0, 1, 4'b0100, 4'b0100, 0, 0);
    foreach (sq[k]) begin
      apply(sq[k]); tick(); total++;
      if (k == mark) snap = o_overflow;
      if (o_valid !== m_valid || o_ch !== m_ch || o_pending !== m_pend || o_overflow !== m_ovf) begin
        bad++;
        $display("FAIL overflow cyc=%0d got v=%b ch=%0d p=%b o=%b want v=%b ch=%0d p=%b o=%b",
                 cyc, o_valid, o_ch, o_pending, o_overflow, m_valid, m_ch, m_pend, m_ovf);
      end
    end
    sq.delete();
    total++;
    if (snap !== 4'b0100 || grants.size() != 1 || grants[0] != 2 || o_overflow !== 4'b0000) begin
      bad++;
      $display("FAIL overflow_flag got ovf_before_clr=%b grants=%0d ovf_after=%b want 0100/1/0000",
               snap, grants.size(), o_overflow);
    end
  endtask

  task automatic test_en_hold();
    int mark;
    logic sv;
    logic [CW-1:0] sc;
    grants.delete();
    sv = 1'b0; sc = '0;
    add(1, 1, 1, 4'b1111, 4'b0000, 0, 0);
    add(4, 0, 1, 4'b1111, 4'b0000, 0, 0);
    add(5, 0, 1, 4'b1111, 4'b0010, 0, 0);
    add(3, 0, 0, 4'b1111, 4'b0011, 0, 0);
    mark = sq.size() - 1;
    add(1, 0, 0, 4'b1111, 4'b0011, 1, 0);
    add(6, 0, 1, 4'b1111, 4'b0011, 1, 0);
    foreach (sq[k]) begin
      apply(sq[k]); tick(); total++;
      if (k == mark) begin sv = o_valid; sc = o_ch; end
      if (o_valid !== m_valid || o_ch !== m_ch || o_pending !== m_pend || o_overflow !== m_ovf) begin
        bad++;
        $display("FAIL en_hold cyc=%0d got v=%b ch=%0d p=%b o=%b want v=%b ch=%0d p=%b o=%b",
                 cyc, o_valid, o_ch, o_pending, o_overflow, m_valid, m_ch, m_pend, m_ovf);
      end
    end
    sq.delete();
    total++;
    if (sv !== 1'b1 || sc !== 2'd1 || grants.size() != 1 || grants[0] != 1 || o_pending !== 4'b0000) begin
      bad++;
      $display("FAIL en_hold_offer got v=%b ch=%0d grants=%0d pend=%b want 1/1/1/0000", sv, sc, grants.size(), o_pending);
    end
  endtask

  task automatic test_reset_mid_offer();
    int mark;
    logic sv;
    logic [N-1:0] sp, so;
    grants.delete();
    sv = 1'b1; sp = '1; so = '1;
    add(1, 1, 1, 4'b1111, 4'b0000, 0, 0);
    add(4, 0, 1, 4'b1111, 4'b0000, 0, 0);
    add(4, 0, 1, 4'b1111, 4'b0101, 0, 0);
    add(1, 0, 1, 4'b1111, 4'b0101, 1, 0);
    add(4, 0, 1, 4'b1111, 4'b0101, 0, 0);
    add(2, 0, 1, 4'b1111, 4'b0001, 0, 0);
    add(3, 0, 1, 4'b1111, 4'b0101, 0, 0);
    add(1, 1, 1, 4'b1111, 4'b0101, 0, 0);
    mark = sq.size() - 1;
    add(4, 0, 1, 4'b1111, 4'b0101, 1, 0);
    add(3, 0, 1, 4'b1111, 4'b0000, 1, 0);
    add(10, 0, 1, 4'b1111, 4'b0011, 1, 0);
    foreach (sq[k]) begin
      apply(sq[k]); tick(); total++;
      if (k == mark) begin sv = o_valid; sp = o_pending; so = o_overflow; end
      if (o_valid !== m_valid || o_ch !== m_ch || o_pending !== m_pend || o_overflow !== m_ovf) begin
        bad++;
        $display("FAIL rst_mid cyc=%0d got v=%b ch=%0d p=%b o=%b want v=%b ch=%0d p=%b o=%b",
                 cyc, o_valid, o_ch, o_pending, o_overflow, m_valid, m_ch, m_pend, m_ovf);
      end
    end
    sq.delete();
    total++;
    if (sv !== 1'b0 || sp !== 4'b0000 || so !== 4'b0000 || grants.size() != 3 ||
        grants[0] != 0 || grants[1] != 0 || grants[2] != 1) begin
      bad++;
      $display("FAIL rst_mid_state got v=%b p=%b o=%b grants=%0d want 0/0000/0000 and grants 0,0,1",
               sv, sp, so, grants.size());
    end
  endtask

  task automatic test_random();
    stim_t e;
    logic [N-1:0] sig, pos, m;
    sig = '0; pos = 4'b1010;
    add(1, 1, 1, pos, sig, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      m = '0;
      for (int b = 0; b < N; b++) m[b] = ($urandom_range(3) == 0);
      sig = sig ^ m;
      if ($urandom_range(49) == 0) pos = N'($urandom);
      e.rst = ($urandom_range(199) == 0); e.en = ($urandom_range(7) != 0);
      e.ready = $urandom_range(1) == 1; e.clr = ($urandom_range(29) == 0);
      e.pos = pos; e.sig = sig;
      sq.push_back(e);
    end
    foreach (sq[k]) begin
      apply(sq[k]); tick(); total++;
      if (o_valid !== m_valid || o_ch !== m_ch || o_pending !== m_pend || o_overflow !== m_ovf) begin
        bad++;
        $display("FAIL random cyc=%0d got v=%b ch=%0d p=%b o=%b want v=%b ch=%0d p=%b o=%b",
                 cyc, o_valid, o_ch, o_pending, o_overflow, m_valid, m_ch, m_pend, m_ovf);
      end
    end
    sq.delete();
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b1; i_pos_edge = '0; i_signal = '0; i_ready = 1'b0; i_clr_ovf = 1'b0;
    m_prev = '0; m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_ch = '0; m_rr = 0; m_prime = PRIME;
`ifdef EDGE_ARB_SYNC_EN
    m_s1 = '0; m_s2 = '0;
`endif
    test_reset();
    test_single_rise();
    test_multi_fall();
    test_overflow();
    test_en_hold();
    test_reset_mid_offer();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
